// File: rtl/calc_sequencer.sv
// Purpose: button-driven operand load / calculate / show sequencer with synchronised, edge-detected buttons.
// Latency: a button edge sampled at clock edge k changes the outputs at edge k+SYNC_STAGES+1; every output is registered.
// Backpressure: none; the datapath strobe calc_done is honoured only in CALCULATE, and only after the calc_start cycle.
module calc_sequencer #(
    parameter int NUM_OPERANDS = 2,
    parameter int IDX_W        = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btnr,
    input  logic             btnl,
    input  logic             calc_done,
    output logic [1:0]       state,
    output logic [IDX_W-1:0] operand_idx,
    output logic             load_en,
    output logic             calc_start,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        S_WAIT = 2'b00,
        S_LOAD = 2'b01,
        S_CALC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

    logic [SYNC_STAGES-1:0] sync_r, sync_l;
    logic                   prev_r, prev_l;
    logic                   rise_r, rise_l;

    state_t           st_q, st_n;
    logic [IDX_W-1:0] idx_n;
    logic             ld_n, cs_n, rv_n;

    // The rise flags are themselves registered, which sets the k+SYNC_STAGES+1 latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            sync_l <= '0;
            prev_r <= 1'b0;
            prev_l <= 1'b0;
            rise_r <= 1'b0;
            rise_l <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btnr};
            sync_l <= {sync_l[SYNC_STAGES-2:0], btnl};
            prev_r <= sync_r[SYNC_STAGES-1];
            prev_l <= sync_l[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
            rise_l <= sync_l[SYNC_STAGES-1] & ~prev_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= S_WAIT;
            operand_idx  <= '0;
            load_en      <= 1'b0;
            calc_start   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            st_q         <= st_n;
            operand_idx  <= idx_n;
            load_en      <= ld_n;
            calc_start   <= cs_n;
            result_valid <= rv_n;
        end
    end

    // In LOAD the index advances one cycle after the load_en pulse so the pulse sees the old index.
    always_comb begin
        st_n  = st_q;
        idx_n = operand_idx;
        ld_n  = 1'b0;
        cs_n  = 1'b0;
        rv_n  = result_valid;
        if (rise_l) begin
            st_n  = S_WAIT;
            idx_n = '0;
            rv_n  = 1'b0;
        end else begin
            case (st_q)
                S_WAIT: begin
                    if (rise_r) begin
                        st_n  = S_LOAD;
                        idx_n = '0;
                    end
                end
                S_LOAD: begin
                    if (load_en) begin
                        if (operand_idx < LAST_IDX) begin
                            idx_n = operand_idx + IDX_W'(1);
                        end else begin
                            st_n = S_CALC;
                            cs_n = 1'b1;
                        end
                    end else if (rise_r) begin
                        ld_n = 1'b1;
                    end
                end
                S_CALC: begin
                    if (calc_done && !calc_start) begin
                        st_n = S_SHOW;
                        rv_n = 1'b1;
                    end
                end
                S_SHOW: begin
                    if (rise_r) begin
                        st_n  = S_LOAD;
                        idx_n = '0;
                        rv_n  = 1'b0;
                    end
                end
                default: st_n = S_WAIT;
            endcase
        end
    end

    assign state = st_q;

endmodule
